axi_sram_slave: RTL
===================

# axi_sram_slave

AXI3 slave responder that terminates the CPU's AXI master port (`ar*`/`r*`/`aw*`/`w*`/`b*`) with an internal word-addressed RAM. It is the bench-side and SoC-side counterpart of the SRAM-to-AXI bridge. It serves INCR and FIXED bursts of up to 16 beats, with one outstanding read and one outstanding write. The read and write channels are fully independent.

## Interface
- `MEM_AW`, default 12: RAM word-address width (2^MEM_AW 32-bit words); `addr[MEM_AW+1:2]` indexes RAM, upper bits ignored (aliasing).
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  reset; one clock; reset is synchronous and active-low.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`/`arlock`/`arcache`/`arprot`  in  4/32/8/3/2/2/4/3  read address; `arlock`/`arcache`/`arprot` ignored.
- `arvalid` in 1, `arready` out 1  read address handshake.
- `rid` out 4, `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1  read data.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`/`awlock`/`awcache`/`awprot`  in  same widths  write address; lock/cache/prot ignored.
- `awvalid` in 1, `awready` out 1  write address handshake.
- `wid` in 4, `wdata` in 32, `wstrb` in 4, `wlast` in 1, `wvalid` in 1, `wready` out 1  write data; `wid` ignored.
- `bid` out 4, `bresp` out 2, `bvalid` out 1, `bready` in 1  write response.

## Operation
- Read FSM: R_IDLE, then R_DATA.
  - R_IDLE: `arready`=1. On `arvalid&arready`, latch id, word address, len, burst; clear beat counter; go to R_DATA.
  - R_DATA: `rvalid`=1 and `rdata`=RAM[addr] (combinational array read). `rlast`=(beat==len). `rresp`=00. `rid`=latched id.
  - On `rvalid&rready`: if beat==len, go to R_IDLE; else beat+1 and addr+1 word (INCR) or addr held (FIXED).
- Burst type WRAP (10) and reserved (11) are served as INCR; `rresp`=10 (SLVERR) on every beat of such a burst.
- Burst length is `arlen[3:0]`+1. A nonzero `arlen[7:4]` is treated as `arlen[3:0]`, with SLVERR.
- `arsize` is ignored; every beat is a full 32-bit word. Sub-word selection is done with `wstrb` (writes) and by the requester (reads).
- Word address increments wrap modulo 2^MEM_AW.
- Write FSM: W_IDLE, then W_DATA, then W_RESP.
  - W_IDLE: `awready`=1. On handshake, latch id, address, len, burst (same rules as reads); go to W_DATA.
  - W_DATA: `wready`=1. Each `wvalid&wready` writes byte lanes i where `wstrb[i]`=1, advances the address like reads, and increments beat.
  - A beat with `wlast`=1, or beat==len, ends the burst and moves to W_RESP.
  - Error flag is set if `wlast` and (beat==len) disagree on that beat, or if burst/len was illegal.
  - W_RESP: `bvalid`=1, `bid`=latched id, `bresp`=10 if error flag else 00. On `bready`, go to W_IDLE.
- Same-cycle write beat and read beat to the same word: the read returns the old value; the new value is visible from the next cycle.
- RAM contents are not reset.

## Timing
- While `resetn`=0, all outputs are forced low: ready/valid signals = 0, `rdata`/`rid`/`bid`/`rresp`/`bresp`/`rlast` = 0. Both FSMs go to their IDLE state. First `arready`/`awready`=1 in the cycle after `resetn` rises.
- AR handshake at cycle T: first `rvalid` at T+1. Back-to-back beats are possible with `rready`=1 (one beat/cycle). Next AR is accepted at the cycle after the last R handshake.
- AW handshake at T: `wready` at T+1. Last W beat at T: `bvalid` at T+1. Next AW is accepted after the B handshake.
- `rvalid`/`bvalid`, once high, hold with stable payload until the handshake.
- Reset asserted mid-burst: transaction abandoned; any partially written words remain written; no B response is issued.

## Configuration
- `AXI_SLAVE_RAND_DELAY_EN` defined: a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - When `lfsr[1:0]`==00, that cycle is a stall: `arready`, `awready` and `wready` are forced 0.
  - A pending `rvalid` or `bvalid` that has not yet been raised is held off one more cycle. Outputs that are already high are never dropped.
- Undefined: no stalls; the latencies in Timing are exact.

## Test plan
- Single write then read: AW addr 0x100, len 0, `wdata` 0x12345678, `wstrb` 1111 → `bresp` 00, `bid`=awid. Then AR 0x100 → `rdata` 0x12345678, `rlast`=1, `rresp` 00, `rvalid` at T+1.
- Byte strobe: word 0x200 preset to 0xFFFFFFFF, write 0x00AB0000 with `wstrb` 0100 → read returns 0xFFABFFFF.
- INCR burst, len 3: write 1,2,3,4 at 0x300 → reads at 0x300..0x30C return 1..4; `rlast` only on beat 4. With `rready` toggling 1/0, each beat holds until accepted.
- FIXED burst, len 2, at 0x400 with data A,B,C → word 0x400 = C; neighbouring words unchanged.
- Early `wlast` on beat 2 of a len=3 write → `bresp`=10, exactly 2 words written. WRAP read → all beats `rresp`=10.
- Reset mid-read burst (beat 2 of 4) → next cycle `rvalid`=0. A new AR is accepted one cycle after `resetn` rises and returns correct data.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave terminating a CPU master port on an internal
// word-addressed RAM. Independent read/write FSMs, one outstanding burst each,
// INCR/FIXED bursts up to 16 beats (WRAP/reserved served as INCR + SLVERR).
// Optional macro AXI_SLAVE_RAND_DELAY_EN: LFSR-driven ready stalls and
// valid hold-off for stress testing the master.
module axi_sram_slave #(
    parameter int MEM_AW = 12
) (
    input  logic        clk,
    input  logic        resetn,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [2**MEM_AW];

    // Sideband and sub-word address bits carry no meaning for a word RAM.
    logic unused_bits;
    assign unused_bits = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache,
                           awprot, wid, araddr[1:0], araddr[31:MEM_AW+2],
                           awaddr[1:0], awaddr[31:MEM_AW+2]};

    logic stall;

`ifdef AXI_SLAVE_RAND_DELAY_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) choosing stall cycles.
    always_ff @(posedge clk) begin
        if (!resetn) lfsr <= 16'hACE1;
        else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // ------------------------------------------------------------ read side
    r_state_t          r_state, r_next;
    logic [3:0]        r_id, r_len, r_beat;
    logic [MEM_AW-1:0] r_addr;
    logic              r_fixed, r_err, r_shown;
    logic              r_valid_int, ar_hs, r_hs, r_done;

    assign ar_hs  = arvalid & arready;
    assign r_hs   = rvalid & rready;
    assign r_done = (r_beat == r_len);

    // Read state register.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    // Read next-state and handshake outputs; outputs held low in reset.
    always_comb begin
        r_next      = r_state;
        arready     = 1'b0;
        r_valid_int = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = resetn & ~stall;
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: begin
                // once shown, rvalid is never withdrawn by a stall
                r_valid_int = r_shown | ~stall;
                if (r_hs && r_done) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign rvalid = resetn & r_valid_int;
    assign rid    = rvalid ? r_id : 4'd0;
    assign rdata  = rvalid ? mem[r_addr] : 32'd0;
    assign rresp  = (rvalid & r_err) ? RESP_SLVERR : 2'b00;
    assign rlast  = rvalid & r_done;

    // Read burst bookkeeping: latch command, step beat/address per R handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_fixed <= 1'b0;
            r_err   <= 1'b0;
            r_shown <= 1'b0;
        end else if (ar_hs) begin
            r_id    <= arid;
            r_addr  <= araddr[MEM_AW+1:2];
            r_len   <= arlen[3:0];
            r_beat  <= '0;
            r_fixed <= (arburst == BURST_FIXED);
            r_err   <= arburst[1] | (|arlen[7:4]);
            r_shown <= 1'b0;
        end else if (r_state == R_DATA) begin
            r_shown <= r_shown | r_valid_int;
            if (r_hs) begin
                r_beat <= r_beat + 4'd1;
                if (!r_fixed) r_addr <= r_addr + 1'b1;
            end
        end
    end

    // ----------------------------------------------------------- write side
    w_state_t          w_state, w_next;
    logic [3:0]        w_id, w_len, w_beat;
    logic [MEM_AW-1:0] w_addr;
    logic              w_fixed, w_err, b_shown;
    logic              b_valid_int, aw_hs, w_hs, b_hs, w_at_len, w_end;

    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign b_hs     = bvalid & bready;
    assign w_at_len = (w_beat == w_len);
    assign w_end    = w_hs & (wlast | w_at_len);

    // Write state register.
    always_ff @(posedge clk) begin
        if (!resetn) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    // Write next-state and handshake outputs; outputs held low in reset.
    always_comb begin
        w_next      = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        b_valid_int = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = resetn & ~stall;
                if (aw_hs) w_next = W_DATA;
            end
            W_DATA: begin
                wready = resetn & ~stall;
                if (w_end) w_next = W_RESP;
            end
            W_RESP: begin
                b_valid_int = b_shown | ~stall;
                if (b_hs) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign bvalid = resetn & b_valid_int;
    assign bid    = bvalid ? w_id : 4'd0;
    assign bresp  = (bvalid & w_err) ? RESP_SLVERR : 2'b00;

    // Write burst bookkeeping; a wlast that disagrees with the length flags an error.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_fixed <= 1'b0;
            w_err   <= 1'b0;
            b_shown <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= awid;
            w_addr  <= awaddr[MEM_AW+1:2];
            w_len   <= awlen[3:0];
            w_beat  <= '0;
            w_fixed <= (awburst == BURST_FIXED);
            w_err   <= awburst[1] | (|awlen[7:4]);
            b_shown <= 1'b0;
        end else begin
            if (w_hs) begin
                w_beat <= w_beat + 4'd1;
                if (!w_fixed) w_addr <= w_addr + 1'b1;
                if (wlast != w_at_len) w_err <= 1'b1;
            end
            if (w_state == W_RESP) b_shown <= b_shown | b_valid_int;
        end
    end

    // RAM byte-lane writes; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[w_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
